// File: rtl/spike_pkg.sv
// ---------------------------------------------------------------------------
// spike_pkg : shared FSM state encoding and sizing constants for the driver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spike_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam int c_MAX_BATCH = 1024;
  localparam int c_ACC_W     = 32;
  localparam int c_CNT_W     = $clog2(c_MAX_BATCH + 1);
  localparam int c_RES_W     = 16;

endpackage

`default_nettype wire

// File: rtl/spike_acc.sv
// ---------------------------------------------------------------------------
// spike_acc : wrapping signed accumulator of array results plus return count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spike_acc
  import spike_pkg::*;
#(
  parameter int ACC_W = c_ACC_W,
  parameter int CNT_W = c_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [c_RES_W-1:0] i_result,
  output logic [ACC_W-1:0]   o_acc,
  output logic [CNT_W-1:0]   o_returned
);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_returned;
  logic [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W - c_RES_W){i_result[c_RES_W-1]}}, i_result};

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc      <= '0;
      r_returned <= '0;
    end else if (i_en) begin
      r_acc      <= r_acc + w_ext;
      r_returned <= r_returned + CNT_W'(1);
    end
  end

  assign o_acc      = r_acc;
  assign o_returned = r_returned;

endmodule

`default_nettype wire

// File: rtl/spike_array_driver.sv
// ---------------------------------------------------------------------------
// spike_array_driver : job FSM issuing operand vectors to the spike array and
// totalling its results. Optional watchdog: define SPIKE_DRV_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spike_array_driver
  import spike_pkg::*;
#(
  parameter int N         = 128,
  parameter int BITWIDTH  = 4,
  parameter int MAX_BATCH = c_MAX_BATCH,
  parameter int ACC_W     = c_ACC_W
`ifdef SPIKE_DRV_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [10:0]           cmd_batches,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*4-1:0]        in_weights,
  input  logic [N*BITWIDTH-1:0] in_acts,
  output logic                  o_start,
  output logic [N*4-1:0]        o_weights_flat,
  output logic [N*BITWIDTH-1:0] o_acts_flat,
  input  logic                  i_done,
  input  logic [c_RES_W-1:0]    i_result,
  output logic                  acc_valid,
  output logic [ACC_W-1:0]      acc_out,
  output logic                  busy,
  output logic                  err
);

  localparam int c_BCNT_W = $clog2(MAX_BATCH + 1);

  state_t                r_state;
  state_t                w_next;
  logic [c_BCNT_W-1:0]   r_count;
  logic [c_BCNT_W-1:0]   r_issued;
  logic [c_BCNT_W-1:0]   w_returned;
  logic [c_BCNT_W-1:0]   w_clamped;
  logic                  r_start;
  logic [N*4-1:0]        r_weights;
  logic [N*BITWIDTH-1:0] r_acts;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_active;
  logic                  w_acc_en;
  logic                  w_stray;
  logic                  w_tmo;

  assign w_clamped = (32'(cmd_batches) > 32'(MAX_BATCH)) ? c_BCNT_W'(MAX_BATCH)
                                                         : c_BCNT_W'(cmd_batches);

  assign w_active = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign in_ready = (r_state == S_ISSUE) && (r_issued < r_count);
  assign w_issue  = in_valid && in_ready;
  // A done is only counted while the job still owes results; anything else is stray.
  assign w_acc_en = i_done && w_active && (w_returned < r_count);
  assign w_stray  = i_done && !w_acc_en;

`ifdef SPIKE_DRV_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT + 1);
  logic [c_TMO_W-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (rst || w_issue || i_done || !w_active || !(w_returned < r_issued)) begin
      r_tmo <= '0;
    end else if (r_tmo != c_TMO_W'(TIMEOUT)) begin
      r_tmo <= r_tmo + c_TMO_W'(1);
    end
  end

  assign w_tmo = w_active && (r_tmo == c_TMO_W'(TIMEOUT));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = (w_clamped == '0) ? S_REPORT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_tmo) begin
          w_next = S_REPORT;
        end else if (w_issue && ((r_issued + c_BCNT_W'(1)) == r_count)) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_tmo || (w_returned == r_count)) begin
          w_next = S_REPORT;
        end
      end
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start   <= 1'b0;
      r_weights <= '0;
      r_acts    <= '0;
      r_issued  <= '0;
      r_count   <= '0;
    end else begin
      r_start <= w_issue;
      if (w_accept) begin
        r_count  <= w_clamped;
        r_issued <= '0;
      end
      if (w_issue) begin
        r_weights <= in_weights;
        r_acts    <= in_acts;
        r_issued  <= r_issued + c_BCNT_W'(1);
      end
    end
  end

  // Setting wins over the accept clear so a stray in the accept cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_stray || w_tmo) begin
      r_err <= 1'b1;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end
  end

  spike_acc #(
    .ACC_W (ACC_W),
    .CNT_W (c_BCNT_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_en       (w_acc_en),
    .i_result   (i_result),
    .o_acc      (acc_out),
    .o_returned (w_returned)
  );

  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign acc_valid      = (r_state == S_REPORT);
  assign o_start        = r_start;
  assign o_weights_flat = r_weights;
  assign o_acts_flat    = r_acts;
  assign err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spike_array_driver.sv
// ---------------------------------------------------------------------------
// tb_spike_array_driver : directed bench with a fixed-latency array model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spike_array_driver;

  localparam int N  = 128;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [10:0]       cmd_batches = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*4-1:0]    in_weights = '0;
  logic [N*BW-1:0]   in_acts = '0;
  logic              o_start;
  logic [N*4-1:0]    o_weights_flat;
  logic [N*BW-1:0]   o_acts_flat;
  logic              i_done;
  logic [15:0]       i_result;
  logic              acc_valid;
  logic [31:0]       acc_out;
  logic              busy;
  logic              err;

  logic              m_done = 1'b0;
  logic [15:0]       m_res = '0;
  logic              s_done = 1'b0;
  logic [2:0]        pipe = '0;
  logic [15:0]       res_q[$];

  int total = 0;
  int bad   = 0;

  assign i_done   = m_done | s_done;
  assign i_result = m_res;

  always #5 clk = ~clk;

  spike_array_driver dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_batches    (cmd_batches),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_weights     (in_weights),
    .in_acts        (in_acts),
    .o_start        (o_start),
    .o_weights_flat (o_weights_flat),
    .o_acts_flat    (o_acts_flat),
    .i_done         (i_done),
    .i_result       (i_result),
    .acc_valid      (acc_valid),
    .acc_out        (acc_out),
    .busy           (busy),
    .err            (err)
  );

  // Array model: each o_start returns the next queued result three edges later.
  always @(negedge clk) begin
    m_done = 1'b0;
    m_res  = '0;
    if (rst) begin
      pipe = '0;
    end else begin
      pipe = {pipe[1:0], o_start};
      if (pipe[2] && res_q.size() > 0) begin
        m_done = 1'b1;
        m_res  = res_q.pop_front();
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic run_job(input int nb, input bit tgl, input int budget,
                         output int starts, output int maxrun, output int serr,
                         output int vcyc, output logic [31:0] vacc, output logic verr);
    int run;
    bit hs;
    starts = 0; maxrun = 0; serr = 0; vcyc = -1; vacc = '0; verr = 1'b0; run = 0;
    cmd_valid   = 1'b1;
    cmd_batches = 11'(nb);
    in_valid    = 1'b1;
    for (int cyc = 1; cyc <= budget && vcyc < 0; cyc++) begin
      hs = in_valid && in_ready;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (o_start !== hs) serr++;
      if (o_start === 1'b1) begin
        starts++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (acc_valid === 1'b1) begin
        vcyc = cyc;
        vacc = acc_out;
        verr = err;
      end
      if (tgl) in_valid = !in_valid;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int          starts, maxrun, serr, vcyc;
    logic [31:0] vacc;
    logic        verr;
    logic [N*4-1:0]  exp_w;
    logic [N*BW-1:0] exp_a;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_start", 64'(o_start), 0);
    chk("rst_acc_valid", 64'(acc_valid), 0);
    chk("rst_acc_out", 64'(acc_out), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    total++;
    assert (o_weights_flat === '0 && o_acts_flat === '0) else begin
      bad++;
      $error("FAIL rst_operands: observed=%0h expected=0", o_weights_flat[31:0]);
    end
    rst = 1'b0;
    @(negedge clk);

    // Four batches, back-to-back, mixed-sign results.
    exp_w = {N{4'b1001}};
    exp_a = {N{4'b0110}};
    in_weights = exp_w;
    in_acts    = exp_a;
    res_q = {16'sd10, -16'sd3, 16'sd7, -16'sd20};
    run_job(4, 1'b0, 60, starts, maxrun, serr, vcyc, vacc, verr);
    chk("j4_starts", 64'(starts), 4);
    chk("j4_backtoback", 64'(maxrun), 4);
    chk("j4_start_hs", 64'(serr), 0);
    chk("j4_report_cycle", 64'(vcyc), 9);
    chk("j4_acc", $signed(vacc), -6);
    chk("j4_err", 64'(verr), 0);
    total++;
    assert (o_weights_flat === exp_w && o_acts_flat === exp_a) else begin
      bad++;
      $error("FAIL j4_operands: observed=%0h expected=%0h", o_weights_flat[31:0], exp_w[31:0]);
    end
    @(negedge clk);
    chk("j4_valid_one_cycle", 64'(acc_valid), 0);
    chk("j4_idle_after", 64'(busy), 0);
    chk("j4_acc_held", $signed(acc_out), -6);

    // Stray done while idle.
    s_done = 1'b1;
    @(negedge clk);
    s_done = 1'b0;
    chk("stray_err_set", 64'(err), 1);

    // Zero-batch job reports immediately and clears the error.
    run_job(0, 1'b0, 10, starts, maxrun, serr, vcyc, vacc, verr);
    chk("j0_report_cycle", 64'(vcyc), 1);
    chk("j0_acc", $signed(vacc), 0);
    chk("j0_starts", 64'(starts), 0);
    chk("j0_err_cleared", 64'(verr), 0);
    @(negedge clk);

    // Oversized job clamps to the maximum batch count.
    res_q.delete();
    for (int i = 0; i < 1024; i++) res_q.push_back(16'sd1);
    run_job(2000, 1'b0, 1100, starts, maxrun, serr, vcyc, vacc, verr);
    chk("clamp_starts", 64'(starts), 1024);
    chk("clamp_backtoback", 64'(maxrun), 1024);
    chk("clamp_acc", $signed(vacc), 1024);
    @(negedge clk);

    // Gapped operand stream, results whose sum exceeds 16 bits.
    res_q = {16'sh7fff, 16'sh7fff, 16'sh7fff};
    run_job(3, 1'b1, 60, starts, maxrun, serr, vcyc, vacc, verr);
    chk("gap_starts", 64'(starts), 3);
    chk("gap_start_hs", 64'(serr), 0);
    chk("gap_acc", $signed(vacc), 98301);
    chk("gap_err", 64'(verr), 0);
    @(negedge clk);

`ifdef SPIKE_DRV_TIMEOUT_EN
    res_q = {16'sd5, 16'sd6};
    run_job(3, 1'b0, 300, starts, maxrun, serr, vcyc, vacc, verr);
    chk("tmo_starts", 64'(starts), 3);
    chk("tmo_acc", $signed(vacc), 11);
    chk("tmo_err", 64'(verr), 1);
    @(negedge clk);
    chk("tmo_idle", 64'(cmd_ready), 1);
    @(negedge clk);
`endif

    // Reset in the middle of an issue phase abandons the job.
    res_q.delete();
    cmd_valid   = 1'b1;
    cmd_batches = 11'd5;
    in_valid    = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 1);
    chk("mid_in_ready", 64'(in_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 1);
    chk("mid_rst_start", 64'(o_start), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
